// File: rtl/scoreboard_register_file.sv
// Register file with two bypassed read ports, one write port and a per-register
// busy scoreboard for RAW/WAW hazard tracking. Define ZERO_REG_EN to hardwire register 0 to zero.
module scoreboard_register_file #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  input  logic [ADDR_W-1:0]   rd,
  input  logic                write_en,
  input  logic [DATA_W-1:0]   write_data,
  output logic [DATA_W-1:0]   read_data1,
  output logic [DATA_W-1:0]   read_data2,
  output logic                rs1_ready,
  output logic                rs2_ready,
  input  logic                reserve_en,
  input  logic [ADDR_W-1:0]   reserve_addr,
  output logic                reserve_ok,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    busy_count
);

`ifdef ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    busy_count_q, busy_count_d;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  logic write_ok;
  logic reserve_hit;
  assign write_ok = write_en && addr_valid(rd) && !is_zero_reg(rd);

  // Read port 1: invalid or hardwired-zero addresses read as 0 and are always ready.
  always_comb begin
    read_data1 = '0;
    rs1_ready  = 1'b1;
    if (addr_valid(rs1) && !is_zero_reg(rs1)) begin
      read_data1 = (write_en && rd == rs1) ? write_data : regs_q[rs1];
      rs1_ready  = !busy_q[rs1] || (write_en && rd == rs1);
    end
  end

  always_comb begin
    read_data2 = '0;
    rs2_ready  = 1'b1;
    if (addr_valid(rs2) && !is_zero_reg(rs2)) begin
      read_data2 = (write_en && rd == rs2) ? write_data : regs_q[rs2];
      rs2_ready  = !busy_q[rs2] || (write_en && rd == rs2);
    end
  end

  // A write landing this cycle frees the slot for a new producer immediately.
  always_comb begin
    reserve_ok  = 1'b0;
    reserve_hit = 1'b0;
    if (reserve_en && addr_valid(reserve_addr)) begin
      if (is_zero_reg(reserve_addr)) begin
        reserve_ok = 1'b1;
      end else begin
        reserve_ok  = !busy_q[reserve_addr] || (write_en && rd == reserve_addr);
        reserve_hit = reserve_ok;
      end
    end
  end

  // Clear before set so a same-register write+reserve leaves the register busy.
  always_comb begin
    busy_d = busy_q;
    if (write_ok) busy_d[rd] = 1'b0;
    if (reserve_hit) busy_d[reserve_addr] = 1'b1;
    busy_count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_count_d = busy_count_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      if (write_ok) regs_q[rd] <= write_data;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_vec   = busy_q;
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench for scoreboard_register_file: reset, bypass, scoreboard lifecycle,
// WAW stall, write/reserve collision and reset mid-operation (ZERO_REG_EN aware).
module tb_scoreboard_register_file;

`ifdef ZERO_REG_EN
  localparam logic ZERO = 1'b1;
`else
  localparam logic ZERO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rs1, rs2, rd, reserve_addr;
  logic       write_en, reserve_en;
  logic [7:0] write_data, read_data1, read_data2;
  logic       rs1_ready, rs2_ready, reserve_ok;
  logic [3:0] busy_vec;
  logic [2:0] busy_count;

  int n_vec = 0;
  int n_err = 0;

  scoreboard_register_file #(
    .DATA_W(8), .NUM_REGS(4), .ADDR_W(2), .CNT_W(3)
  ) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
    .write_en(write_en), .write_data(write_data),
    .read_data1(read_data1), .read_data2(read_data2),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .reserve_en(reserve_en), .reserve_addr(reserve_addr), .reserve_ok(reserve_ok),
    .busy_vec(busy_vec), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    write_en = 1'b0; reserve_en = 1'b0;
    rd = 2'd0; write_data = 8'h00; reserve_addr = 2'd0;
  endtask

  initial begin
    reset = 1'b0; rs1 = 2'd0; rs2 = 2'd0;
    idle();
    write_en = 1'b1; rd = 2'd1; write_data = 8'h99;  // discarded by reset
    tick();
    reset = 1'b1; idle();
    rs1 = 2'd0; rs2 = 2'd3;
    settle();
    check("rst_rd1", 32'(read_data1), 32'h00);
    check("rst_rd2", 32'(read_data2), 32'h00);
    check("rst_busy", 32'(busy_vec), 32'h0);
    check("rst_cnt", 32'(busy_count), 32'd0);
    check("rst_rdy1", 32'(rs1_ready), 32'd1);
    check("rst_rdy2", 32'(rs2_ready), 32'd1);
    rs2 = 2'd1;
    settle();
    check("rst_discard_wr", 32'(read_data2), 32'h00);

    // Write with same-cycle bypass, then from storage.
    tick();
    write_en = 1'b1; rd = 2'd2; write_data = 8'hA5; rs1 = 2'd2;
    settle();
    check("byp_rd1", 32'(read_data1), 32'hA5);
    check("byp_rdy1", 32'(rs1_ready), 32'd1);
    tick();
    idle();
    settle();
    check("store_rd1", 32'(read_data1), 32'hA5);
    check("nonbusy_wr_busy", 32'(busy_vec), 32'h0);

    // Scoreboard lifecycle on register 1.
    reserve_en = 1'b1; reserve_addr = 2'd1;
    settle();
    check("rsv1_ok", 32'(reserve_ok), 32'd1);
    tick();
    idle(); rs2 = 2'd1;
    settle();
    check("rsv1_busy", 32'(busy_vec), 32'h2);
    check("rsv1_cnt", 32'(busy_count), 32'd1);
    check("rsv1_rdy2", 32'(rs2_ready), 32'd0);
    write_en = 1'b1; rd = 2'd1; write_data = 8'h3C;
    settle();
    check("wb1_rdy2", 32'(rs2_ready), 32'd1);
    check("wb1_rd2", 32'(read_data2), 32'h3C);
    tick();
    idle();
    settle();
    check("wb1_busy", 32'(busy_vec), 32'h0);
    check("wb1_cnt", 32'(busy_count), 32'd0);
    check("wb1_store", 32'(read_data2), 32'h3C);

    // WAW stall and write/reserve collision on register 3.
    reserve_en = 1'b1; reserve_addr = 2'd3;
    tick();
    settle();
    check("waw_ok", 32'(reserve_ok), 32'd0);
    tick();
    idle();
    settle();
    check("waw_busy", 32'(busy_vec), 32'h8);
    check("waw_cnt", 32'(busy_count), 32'd1);
    reserve_en = 1'b1; reserve_addr = 2'd3;
    write_en = 1'b1; rd = 2'd3; write_data = 8'h5A; rs1 = 2'd3;
    settle();
    check("col_ok", 32'(reserve_ok), 32'd1);
    check("col_byp", 32'(read_data1), 32'h5A);
    tick();
    idle();
    settle();
    check("col_store", 32'(read_data1), 32'h5A);
    check("col_busy", 32'(busy_vec), 32'h8);
    check("col_rdy1", 32'(rs1_ready), 32'd0);
    check("col_cnt", 32'(busy_count), 32'd1);

    // Fill the scoreboard.
    for (int r = 0; r < 3; r++) begin
      reserve_en = 1'b1; reserve_addr = 2'(r);
      tick();
    end
    idle();
    settle();
    check("full_busy", 32'(busy_vec), ZERO ? 32'hE : 32'hF);
    check("full_cnt", 32'(busy_count), ZERO ? 32'd3 : 32'd4);

    // Reset in a cycle that also carries a write.
    reset = 1'b0; write_en = 1'b1; rd = 2'd0; write_data = 8'hFF;
    tick();
    reset = 1'b1; idle();
    rs1 = 2'd0; rs2 = 2'd3;
    settle();
    check("mrst_rd1", 32'(read_data1), 32'h00);
    check("mrst_rd2", 32'(read_data2), 32'h00);
    check("mrst_busy", 32'(busy_vec), 32'h0);
    check("mrst_cnt", 32'(busy_count), 32'd0);
    rs1 = 2'd1; rs2 = 2'd2;
    settle();
    check("mrst_r1", 32'(read_data1), 32'h00);
    check("mrst_r2", 32'(read_data2), 32'h00);

    // Register 0: general purpose, or hardwired zero under ZERO_REG_EN.
    tick();
    write_en = 1'b1; rd = 2'd0; write_data = 8'h77; rs1 = 2'd0;
    settle();
    check("r0_wr_cycle", 32'(read_data1), ZERO ? 32'h00 : 32'h77);
    tick();
    idle();
    settle();
    check("r0_next", 32'(read_data1), ZERO ? 32'h00 : 32'h77);
    reserve_en = 1'b1; reserve_addr = 2'd0;
    settle();
    check("r0_rsv_ok", 32'(reserve_ok), 32'd1);
    tick();
    idle();
    settle();
    check("r0_busy", 32'(busy_vec), ZERO ? 32'h0 : 32'h1);
    check("r0_rdy1", 32'(rs1_ready), ZERO ? 32'd1 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
